// File: rtl/max7219_pkg.sv
// Shared constants and FSM encoding for the MAX7219 frame sequencer.
package max7219_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCAN      = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int unsigned INIT_LEN = 13;
  localparam int unsigned UPD_LEN  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT
  } seq_state_t;

endpackage

// File: rtl/max7219_face_rom.sv
// Combinational face bitmap ROM: one byte per matrix row, row 0 first.
module max7219_face_rom (
  input  logic [1:0] face,
  input  logic [2:0] row,
  output logic [7:0] row_data
);

  logic [63:0] face_bits;

  // Row 0 sits in the most significant byte, so ~row selects the byte lane.
  always_comb begin
    unique case (face)
      2'd0:    face_bits = 64'h3C7E_DBFF_BDC3_7E3C;
      2'd1:    face_bits = 64'h3C7E_DBFF_FF81_7E3C;
      2'd2:    face_bits = 64'h3C7E_DBFF_FFC3_BD7E;
      default: face_bits = 64'hFFBD_DBE7_E7DB_BDFF;
    endcase
    row_data = face_bits[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// Sequences MAX7219 register writes (init after reset, row updates on change
// or refresh) through a str/busy handshake with the SPI driver.
module max7219_frame_sequencer
  import max7219_pkg::*;
#(
  parameter logic [3:0]  INTENSITY     = 4'h0,
  parameter logic [2:0]  SCAN_LIMIT    = 3'd7,
  parameter int unsigned REFRESH_TICKS = 5000000,
  parameter int unsigned BUSY_TIMEOUT  = 16
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic [1:0] face_sel,
  input  logic       shutdown,
  input  logic       busy,
  output logic       str,
  output logic [7:0] IRreg,
  output logic [7:0] data,
  output logic       frame_done,
  output logic       seq_busy
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  seq_state_t state, next_state;

  logic [1:0]    face_q;
  logic          shut_q;
  logic          init_pending;
  logic          pending;
  logic          refresh_hit;
  logic          refresh_wrap;
  logic          seq_init;
  logic [3:0]    idx;
  logic [TW-1:0] tmo;
  logic          last_word;
  logic          trigger;

  logic          load_word;
  logic          advance;
  logic [1:0]    w_face;
  logic          w_shut;
  logic          w_init;
  logic [3:0]    w_idx;
  logic [2:0]    w_row;
  logic [7:0]    w_addr;
  logic [7:0]    w_data;
  logic [7:0]    rom_byte;

  max7219_face_rom u_face_rom (
    .face     (w_face),
    .row      (w_row),
    .row_data (rom_byte)
  );

  // The first word is fetched in LOAD, the same edge that snapshots the
  // inputs, so it reads the live inputs instead of the not-yet-written copies.
  always_comb begin
    load_word = (state == S_LOAD);
    w_face    = load_word ? face_sel : face_q;
    w_shut    = load_word ? shutdown : shut_q;
    w_init    = load_word ? init_pending : seq_init;
    w_idx     = load_word ? 4'd0 : idx + 4'd1;
    w_row     = 3'(w_idx - (w_init ? 4'd5 : 4'd1));
    w_addr    = REG_DIGIT0 + {5'b0, w_row};
    w_data    = rom_byte;
    if (w_init) begin
      unique case (w_idx)
        4'd0: begin w_addr = REG_TEST;      w_data = '0;                   end
        4'd1: begin w_addr = REG_DECODE;    w_data = '0;                   end
        4'd2: begin w_addr = REG_INTENSITY; w_data = {4'h0, INTENSITY};    end
        4'd3: begin w_addr = REG_SCAN;      w_data = {5'b0, SCAN_LIMIT};   end
        4'd4: begin w_addr = REG_SHUTDOWN;  w_data = {7'b0, w_shut};       end
        default: ;
      endcase
    end else if (w_idx == 4'd0) begin
      w_addr = REG_SHUTDOWN;
      w_data = {7'b0, w_shut};
    end
  end

  assign last_word = (idx == (seq_init ? 4'(INIT_LEN - 1) : 4'(UPD_LEN - 1)));
  assign trigger   = init_pending | pending | refresh_hit;

  always_comb begin
    next_state = state;
    str        = 1'b0;
    frame_done = 1'b0;
    seq_busy   = (state != S_IDLE);
    advance    = 1'b0;
    unique case (state)
      S_IDLE:    if (trigger) next_state = S_LOAD;
      S_LOAD:    begin next_state = S_ISSUE; advance = 1'b1; end
      S_ISSUE:   begin str = 1'b1; next_state = S_WAIT_HI; end
      S_WAIT_HI: begin
        if (busy)                              next_state = S_WAIT_LO;
        else if (tmo == TW'(BUSY_TIMEOUT - 1)) next_state = S_ISSUE;
      end
      S_WAIT_LO: if (!busy) next_state = S_NEXT;
      S_NEXT: begin
        if (last_word) begin
          frame_done = 1'b1;
          seq_busy   = 1'b0;
          next_state = S_IDLE;
        end else begin
          next_state = S_ISSUE;
          advance    = 1'b1;
        end
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      state        <= S_IDLE;
      IRreg        <= '0;
      data         <= '0;
      idx          <= '0;
      tmo          <= '0;
      face_q       <= face_sel;
      shut_q       <= shutdown;
      init_pending <= 1'b1;
      pending      <= 1'b0;
      refresh_hit  <= 1'b0;
      seq_init     <= 1'b0;
    end else begin
      state <= next_state;
      if (load_word) begin
        face_q       <= face_sel;
        shut_q       <= shutdown;
        seq_init     <= init_pending;
        init_pending <= 1'b0;
        pending      <= 1'b0;
        refresh_hit  <= refresh_wrap;
      end else begin
        if (face_sel != face_q || shutdown != shut_q) pending <= 1'b1;
        if (refresh_wrap) refresh_hit <= 1'b1;
      end
      if (advance) begin
        idx   <= w_idx;
        IRreg <= w_addr;
        data  <= w_data;
      end
      tmo <= (state == S_WAIT_HI && next_state == S_WAIT_HI) ? tmo + 1'b1 : '0;
    end
  end

  if (REFRESH_TICKS == 0) begin : g_no_refresh
    assign refresh_wrap = 1'b0;
  end else begin : g_refresh
    localparam int unsigned CW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    logic [CW-1:0] rcnt;
    assign refresh_wrap = (rcnt == CW'(REFRESH_TICKS - 1));
    always_ff @(posedge sys_clk) begin
      if (!_rst)             rcnt <= '0;
      else if (refresh_wrap) rcnt <= '0;
      else                   rcnt <= rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// Bench: behavioural write-list model with a driver emulation and directed plus random stimulus.
module tb_max7219_frame_sequencer;

  localparam int unsigned RT = 200;
  localparam int unsigned BT = 16;

  logic       sys_clk;
  logic       _rst;
  logic [1:0] face_sel;
  logic       shutdown;
  logic       busy;
  logic       str;
  logic [7:0] IRreg;
  logic [7:0] data;
  logic       frame_done;
  logic       seq_busy;

  max7219_frame_sequencer #(
    .INTENSITY     (4'h0),
    .SCAN_LIMIT    (3'd7),
    .REFRESH_TICKS (RT),
    .BUSY_TIMEOUT  (BT)
  ) dut (
    .sys_clk    (sys_clk),
    ._rst       (_rst),
    .face_sel   (face_sel),
    .shutdown   (shutdown),
    .busy       (busy),
    .str        (str),
    .IRreg      (IRreg),
    .data       (data),
    .frame_done (frame_done),
    .seq_busy   (seq_busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] face_byte(input logic [1:0] f, input int r);
    logic [63:0] v;
    case (f)
      2'd0:    v = 64'h3C7EDBFFBDC37E3C;
      2'd1:    v = 64'h3C7EDBFFFF817E3C;
      2'd2:    v = 64'h3C7EDBFFFFC3BD7E;
      default: v = 64'hFFBDDBE7E7DBBDFF;
    endcase
    return v[63-8*r -: 8];
  endfunction

  logic [15:0] exp_q[$];

  function automatic void push_list(input bit init, input logic [1:0] f, input logic s);
    if (init) begin
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h0900);
      exp_q.push_back(16'h0A00);
      exp_q.push_back(16'h0B07);
    end
    exp_q.push_back({8'h0C, 7'b0, s});
    for (int r = 0; r < 8; r++) exp_q.push_back({8'(r + 1), face_byte(f, r)});
  endfunction

  // Shared between the stimulus and the model/driver process.
  int          busy_len = 20;
  int          ignore_req = 0;
  int          ignore_done = 0;
  bit          active = 0;
  int          cap_n = 0;
  logic [15:0] cap[16];
  logic [15:0] last_seq[16];
  logic [15:0] prev_seq[16];
  int          last_n = 0;
  int          seq_count = 0;
  int          reissues = 0;
  int          start_t = 0;
  int          prev_start_t = 0;

  // Model, driver emulation and per-cycle comparisons.
  initial begin
    logic        r, s, sb_exp;
    logic [1:0]  f;
    logic [1:0]  snap_f;
    logic        snap_s;
    bit          trig, init_due, reissue_exp, prev_sb;
    logic [15:0] reissue_word, prev_word, w;
    int          ncyc, tcyc, bcnt, last_str_t, idle_cnt, stall;
    busy = 1'b0;
    trig = 0; init_due = 0; reissue_exp = 0; prev_sb = 0;
    snap_f = '0; snap_s = 1'b0; prev_word = '0; reissue_word = '0;
    ncyc = 0; tcyc = 0; bcnt = 0; last_str_t = 0; idle_cnt = 0; stall = 0;
    forever begin
      @(posedge sys_clk);
      r = _rst; f = face_sel; s = shutdown;
      @(negedge sys_clk);
      tcyc++;
      if (!r) begin
        chk({str, frame_done, seq_busy, IRreg, data} == 19'd0, "reset_state",
            {13'd0, str, frame_done, seq_busy, IRreg, data}, 32'd0);
        exp_q.delete();
        active = 0; init_due = 1; trig = 1; snap_f = f; snap_s = s;
        ncyc = 0; busy = 1'b0; bcnt = 0; reissue_exp = 0; cap_n = 0;
        prev_word = '0; prev_sb = 0; idle_cnt = 0; stall = 0;
        continue;
      end
      ncyc++;
      if (ncyc % RT == 0) trig = 1;
      if (f != snap_f || s != snap_s) trig = 1;
      if (seq_busy && !prev_sb) begin
        chk(trig, "start_legal", {31'd0, trig}, 32'd1);
        snap_f = face_sel; snap_s = shutdown;
        push_list(init_due, snap_f, snap_s);
        trig = 0; init_due = 0; active = 1; cap_n = 0; stall = 0;
        prev_start_t = start_t; start_t = tcyc;
      end
      sb_exp = active && !frame_done;
      chk(seq_busy === sb_exp, "seq_busy", {31'd0, seq_busy}, {31'd0, sb_exp});
      chk(IRreg[7:4] == 4'h0, "irreg_hi", {24'd0, IRreg}, 32'd0);
      if (str) begin
        stall = 0;
        if (!active) chk(0, "str_idle", 32'd1, 32'd0);
        if (reissue_exp) begin
          chk({IRreg, data} == reissue_word, "reissue_word", {16'd0, IRreg, data}, {16'd0, reissue_word});
          chk(tcyc - last_str_t == BT + 1, "reissue_gap", tcyc - last_str_t, BT + 1);
          reissue_exp = 0; reissues++;
        end else if (exp_q.size() == 0) begin
          chk(0, "extra_str", {16'd0, IRreg, data}, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk({IRreg, data} == w, "word", {16'd0, IRreg, data}, {16'd0, w});
          if (cap_n < 16) cap[cap_n] = {IRreg, data};
          cap_n++;
        end
        last_str_t = tcyc;
        if (ignore_req != ignore_done) begin
          ignore_done++; reissue_exp = 1; reissue_word = {IRreg, data};
        end else begin
          busy = 1'b1; bcnt = busy_len;
        end
      end else begin
        chk({IRreg, data} == prev_word, "hold", {16'd0, IRreg, data}, {16'd0, prev_word});
        if (busy) begin
          bcnt--;
          if (bcnt <= 0) busy = 1'b0;
        end
      end
      if (frame_done) begin
        chk(active && exp_q.size() == 0 && !reissue_exp && !busy, "frame_done_early",
            exp_q.size(), 32'd0);
        prev_seq = last_seq; last_seq = cap; last_n = cap_n;
        seq_count++; active = 0; stall = 0;
      end
      if (active) begin
        stall++;
        if (stall > 100) begin chk(0, "stall", stall, 100); stall = 0; end
      end
      if (trig && !active && !seq_busy) idle_cnt++; else idle_cnt = 0;
      if (idle_cnt > 3) begin chk(0, "missing_start", idle_cnt, 3); idle_cnt = 0; end
      prev_word = {IRreg, data};
      prev_sb = seq_busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done();
    int target = seq_count + 1;
    int n = 0;
    while (seq_count < target && n < 3000) begin tick(1); n++; end
    if (seq_count < target) chk(0, "timeout_done", seq_count, target);
  endtask

  task automatic wait_cap(input int k);
    int n = 0;
    while (!(active && cap_n >= k) && n < 3000) begin @(negedge sys_clk); n++; end
    if (n >= 3000) chk(0, "timeout_cap", cap_n, k);
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge sys_clk);
    while (seq_busy && n < 3000) begin @(negedge sys_clk); n++; end
    if (n >= 3000) chk(0, "timeout_idle", n, 0);
    @(posedge sys_clk); #1;
  endtask

  logic [15:0] init_lit[13] = '{16'h0F00, 16'h0900, 16'h0A00, 16'h0B07, 16'h0C01,
                                16'h013C, 16'h027E, 16'h03DB, 16'h04FF, 16'h05BD,
                                16'h06C3, 16'h077E, 16'h083C};
  logic [15:0] face3_lit[9] = '{16'h0C01, 16'h01FF, 16'h02BD, 16'h03DB, 16'h04E7,
                                16'h05E7, 16'h06DB, 16'h07BD, 16'h08FF};

  task automatic check_init(input string name);
    chk(last_n == 13, name, last_n, 13);
    for (int i = 0; i < 13; i++) chk(last_seq[i] == init_lit[i], name, last_seq[i], init_lit[i]);
  endtask

  task automatic check_face3(input string name);
    chk(last_n == 9, name, last_n, 9);
    for (int i = 0; i < 9; i++) chk(last_seq[i] == face3_lit[i], name, last_seq[i], face3_lit[i]);
  endtask

  initial begin
    int r0;
    _rst = 1'b0; face_sel = 2'd0; shutdown = 1'b1;
    tick(3);
    _rst = 1'b1;
    wait_done();
    check_init("init_seq");
    chk(seq_count == 1, "init_done_count", seq_count, 1);
    chk(reissues == 0, "init_no_reissue", reissues, 0);

    busy_len = 4;
    wait_idle();
    face_sel = 2'd3;
    wait_done();
    check_face3("face3_seq");

    // Face change in the middle of the next (refresh) sequence.
    wait_cap(5);
    face_sel = 2'd1;
    wait_done();
    check_face3("face3_inflight");
    wait_done();
    chk(last_seq[6] == 16'h0681, "face1_row5", last_seq[6], 16'h0681);
    chk(last_seq[0] == 16'h0C01, "face1_shut", last_seq[0], 16'h0C01);

    // Driver ignores the first strobe of the next sequence.
    wait_idle();
    r0 = reissues;
    ignore_req++;
    face_sel = 2'd2;
    wait_done();
    chk(reissues == r0 + 1, "reissue_count", reissues, r0 + 1);
    chk(last_seq[7] == 16'h07BD, "face2_row6", last_seq[7], 16'h07BD);

    // Reset in the middle of the 7th init write.
    wait_idle();
    face_sel = 2'd0;
    wait_done();
    busy_len = 20;
    _rst = 1'b0; tick(1); _rst = 1'b1;
    wait_cap(7);
    _rst = 1'b0; tick(1); _rst = 1'b1;
    wait_done();
    check_init("init_after_reset");

    // Static inputs: refresh-driven updates every RT cycles with identical data.
    busy_len = 4;
    wait_done();
    wait_done();
    wait_done();
    chk(start_t - prev_start_t == RT, "refresh_period", start_t - prev_start_t, RT);
    for (int i = 0; i < 9; i++) chk(last_seq[i] == prev_seq[i], "refresh_data", last_seq[i], prev_seq[i]);

    wait_idle();
    shutdown = 1'b0;
    wait_done();
    chk(last_seq[0] == 16'h0C00, "shutdown_first", last_seq[0], 16'h0C00);

    // Random input activity checked by the model.
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if ($urandom_range(49) == 0) face_sel = 2'($urandom_range(3));
      if ($urandom_range(79) == 0) shutdown = ~shutdown;
      if ($urandom_range(99) == 0) busy_len = 2 + $urandom_range(6);
      if ($urandom_range(199) == 0) ignore_req++;
    end
    wait_idle();
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
